// File: rtl/cwc_trace_reader.sv
// rtl/cwc_trace_reader.sv - ChipWatcher trace buffer read-back onto the JTAG trace scan chain
module cwc_trace_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              jtck,
    input  logic              jrstn,
    input  logic [1:0]        jscan,
    input  logic              jshift,
    input  logic              jupdate,
    output logic              jtdo,
    input  logic              capt_done,
    input  logic [ADDR_W-1:0] capt_ptr,
    output logic              rd_ce,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, PRIME, SHIFT, DONE} state_t;

    state_t              state_q;
    logic                jtdo_q, rd_ce_q, rd_pend_q, busy_q, done_q, nxt_valid_q;
    logic [ADDR_W-1:0]   rd_addr_q, rd_ptr_q;
    logic [DATA_W-1:0]   shreg_q, nxt_q;
    logic [CNT_W-1:0]    fetch_left_q, word_left_q;
    logic [BIT_W-1:0]    bitcnt_q;

    logic                sel, shift_en, arm, fetch_go;
    logic [ADDR_W-1:0]   start_ptr_d, rd_ptr_inc;
    logic                unused_jscan0;

    assign unused_jscan0 = jscan[0];
    assign sel           = jscan[1];
    assign shift_en      = sel & jshift;
    assign arm           = jupdate & sel & capt_done;
    assign start_ptr_d   = (capt_ptr == LAST_ADDR) ? '0 : capt_ptr + ADDR_W'(1);
    assign rd_ptr_inc    = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);
    // At most one read outstanding: issued (rd_ce_q) or awaiting capture (rd_pend_q)
    assign fetch_go      = busy_q & ~nxt_valid_q & (fetch_left_q != '0) & ~rd_ce_q & ~rd_pend_q;

    always_ff @(posedge jtck or negedge jrstn) begin
        if (!jrstn) begin
            state_q      <= IDLE;
            jtdo_q       <= 1'b0;
            rd_ce_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            rd_ptr_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            nxt_valid_q  <= 1'b0;
            nxt_q        <= '0;
            shreg_q      <= '0;
            fetch_left_q <= '0;
            word_left_q  <= '0;
            bitcnt_q     <= '0;
        end else begin
            rd_ce_q   <= 1'b0;
            rd_pend_q <= rd_ce_q;
            if (arm) begin
                // First fetch goes out on the arm edge so SHIFT is reached 3 cycles later
                state_q      <= PRIME;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
                jtdo_q       <= 1'b0;
                nxt_valid_q  <= 1'b0;
                rd_pend_q    <= 1'b0;
                rd_ce_q      <= 1'b1;
                rd_addr_q    <= start_ptr_d;
                rd_ptr_q     <= (start_ptr_d == LAST_ADDR) ? '0 : start_ptr_d + ADDR_W'(1);
                fetch_left_q <= DEPTH_CNT - CNT_W'(1);
                word_left_q  <= DEPTH_CNT;
                bitcnt_q     <= '0;
            end else begin
                if (fetch_go) begin
                    rd_ce_q      <= 1'b1;
                    rd_addr_q    <= rd_ptr_q;
                    rd_ptr_q     <= rd_ptr_inc;
                    fetch_left_q <= fetch_left_q - CNT_W'(1);
                end
                if (rd_pend_q) begin
                    nxt_q       <= rd_data;
                    nxt_valid_q <= 1'b1;
                end
                case (state_q)
                    IDLE: jtdo_q <= 1'b0;
                    PRIME: begin
                        if (nxt_valid_q) begin
                            shreg_q     <= nxt_q;
                            jtdo_q      <= nxt_q[0];
                            nxt_valid_q <= 1'b0;
                            bitcnt_q    <= '0;
                            state_q     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (shift_en) begin
                            if (bitcnt_q == LAST_BIT) begin
                                word_left_q <= word_left_q - CNT_W'(1);
                                if (word_left_q == CNT_W'(1)) begin
                                    state_q <= DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    jtdo_q  <= 1'b0;
                                    shreg_q <= '0;
                                end else begin
                                    shreg_q     <= nxt_q;
                                    jtdo_q      <= nxt_q[0];
                                    nxt_valid_q <= 1'b0;
                                    bitcnt_q    <= '0;
                                end
                            end else begin
                                shreg_q  <= shreg_q >> 1;
                                jtdo_q   <= shreg_q[1];
                                bitcnt_q <= bitcnt_q + BIT_W'(1);
                            end
                        end
                    end
                    default: jtdo_q <= 1'b0;
                endcase
            end
        end
    end

    assign jtdo    = jtdo_q;
    assign rd_ce   = rd_ce_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_cwc_trace_reader.sv
// tb/tb_cwc_trace_reader.sv - self-checking bench for cwc_trace_reader with an 8-word ring
module tb_cwc_trace_reader;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int NBITS  = DEPTH * DATA_W;

    logic              jtck = 1'b0;
    logic              jrstn = 1'b0;
    logic [1:0]        jscan = 2'b00;
    logic              jshift = 1'b0;
    logic              jupdate = 1'b0;
    logic              jtdo;
    logic              capt_done = 1'b0;
    logic [ADDR_W-1:0] capt_ptr = '0;
    logic              rd_ce;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              busy;
    logic              done;

    cwc_trace_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .jtck(jtck), .jrstn(jrstn), .jscan(jscan), .jshift(jshift), .jupdate(jupdate),
        .jtdo(jtdo), .capt_done(capt_done), .capt_ptr(capt_ptr), .rd_ce(rd_ce),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 jtck = ~jtck;

    logic [DATA_W-1:0] ram [DEPTH];
    int addr_log[$];
    bit got[$];
    int checks = 0;
    int errors = 0;

    always @(posedge jtck) begin
        if (rd_ce) begin
            rd_data <= ram[rd_addr % DEPTH];
            addr_log.push_back(int'(rd_addr));
        end
    end

    typedef struct {
        int ptr;
        int mode;
        int first_addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge jtck);
        #1;
    endtask

    task automatic arm(input int ptr);
        capt_ptr = ADDR_W'(ptr);
        capt_done = 1'b1;
        jscan = 2'b10;
        jshift = 1'b0;
        jupdate = 1'b1;
        tick();
        jupdate = 1'b0;
        addr_log.delete();
        repeat (3) tick();
    endtask

    // mode 0: continuous, 1: random stalls/deselects, 2: scripted stall at bit 3 of word 2
    task automatic collect(input int nbits, input int mode, input string name);
        int cyc = 0;
        bit stalled = 0;
        logic held;
        got.delete();
        while (got.size() < nbits && cyc < 2000) begin
            if (mode == 2 && got.size() == 2 * DATA_W + 3 && !stalled) begin
                stalled = 1;
                jshift = 1'b0;
                jscan = 2'b10;
                @(negedge jtck);
                held = jtdo;
                repeat (5) tick();
                jshift = 1'b1;
                jscan = 2'b01;
                repeat (3) tick();
                @(negedge jtck);
                chk({name, " jtdo held in stall"}, 32'(jtdo), 32'(held));
                tick();
            end
            if (mode == 1) begin
                jshift = ($urandom_range(0, 3) != 0);
                jscan = {($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1))};
            end else begin
                jshift = 1'b1;
                jscan = 2'b10;
            end
            @(negedge jtck);
            if (jshift && jscan[1]) got.push_back(jtdo);
            tick();
            cyc++;
        end
        jshift = 1'b0;
        jscan = 2'b10;
        chk({name, " bits collected"}, 32'(got.size()), 32'(nbits));
    endtask

    task automatic check_stream(input int ptr, input string name);
        logic [DATA_W-1:0] gw, ew;
        for (int w = 0; w < DEPTH; w++) begin
            ew = ram[(ptr + 1 + w) % DEPTH];
            gw = '0;
            for (int b = 0; b < DATA_W; b++)
                if (w * DATA_W + b < got.size()) gw[b] = got[w * DATA_W + b];
            chk($sformatf("%s word %0d", name, w), 32'(gw), 32'(ew));
        end
    endtask

    task automatic check_reads(input int ptr, input string name);
        chk({name, " rd_ce count"}, 32'(addr_log.size()), 32'(DEPTH));
        for (int k = 0; k < DEPTH && k < addr_log.size(); k++)
            chk($sformatf("%s rd_addr %0d", name, k), 32'(addr_log[k]), 32'((ptr + 1 + k) % DEPTH));
    endtask

    task automatic check_end(input string name);
        int nz = 0;
        @(negedge jtck);
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " jtdo idle"}, 32'(jtdo), 32'd0);
        jshift = 1'b1;
        repeat (4) begin
            tick();
            @(negedge jtck);
            if (jtdo !== 1'b0) nz++;
        end
        jshift = 1'b0;
        tick();
        chk({name, " extra shifts zero"}, 32'(nz), 32'd0);
    endtask

    task automatic fill_ram(input bit pattern);
        for (int i = 0; i < DEPTH; i++)
            ram[i] = pattern ? DATA_W'(8'hA0 + i) : DATA_W'($urandom_range(0, 255));
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{ptr: 3, mode: 0, first_addr: 4};
        vecs[1] = '{ptr: 7, mode: 0, first_addr: 0};
        vecs[2] = '{ptr: 3, mode: 2, first_addr: 4};
        vecs[3] = '{ptr: 0, mode: 1, first_addr: 1};
        vecs[4] = '{ptr: 6, mode: 1, first_addr: 7};
        vecs[5] = '{ptr: 5, mode: 1, first_addr: 6};

        fill_ram(1);
        repeat (3) tick();
        chk("reset jtdo", 32'(jtdo), 0);
        chk("reset rd_ce", 32'(rd_ce), 0);
        chk("reset rd_addr", 32'(rd_addr), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        jrstn = 1'b1;
        tick();

        // arm attempt without capture complete must be ignored
        addr_log.delete();
        capt_done = 1'b0;
        capt_ptr = 16'd3;
        jscan = 2'b10;
        jupdate = 1'b1;
        tick();
        jupdate = 1'b0;
        repeat (5) tick();
        chk("no-capt busy", 32'(busy), 0);
        chk("no-capt done", 32'(done), 0);
        chk("no-capt rd_ce count", 32'(addr_log.size()), 0);

        // jupdate with the trace chain deselected is ignored too
        capt_done = 1'b1;
        jscan = 2'b01;
        jupdate = 1'b1;
        tick();
        jupdate = 1'b0;
        repeat (3) tick();
        chk("desel busy", 32'(busy), 0);

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            fill_ram(v == 0 || v == 2);
            arm(vecs[v].ptr);
            chk({nm, " busy after arm"}, 32'(busy), 1);
            collect(NBITS, vecs[v].mode, nm);
            check_stream(vecs[v].ptr, nm);
            if (addr_log.size() > 0)
                chk({nm, " first rd_addr"}, 32'(addr_log[0]), 32'(vecs[v].first_addr));
            check_reads(vecs[v].ptr, nm);
            check_end(nm);
        end

        // re-arm mid-stream with a different pointer; stale prefetched word must not leak
        fill_ram(0);
        arm(4);
        collect(20, 0, "rearm pre");
        arm(2);
        collect(NBITS, 0, "rearm");
        check_stream(2, "rearm");
        check_reads(2, "rearm");
        check_end("rearm");

        // asynchronous reset during SHIFT, then a clean readout
        arm(1);
        collect(10, 0, "rst pre");
        @(negedge jtck);
        #2;
        jrstn = 1'b0;
        #1;
        chk("midrst jtdo", 32'(jtdo), 0);
        chk("midrst rd_ce", 32'(rd_ce), 0);
        chk("midrst rd_addr", 32'(rd_addr), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        tick();
        jrstn = 1'b1;
        tick();
        arm(1);
        collect(NBITS, 0, "postrst");
        check_stream(1, "postrst");
        check_end("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
